load_store_unit: RTL
====================

# load_store_unit

Initiator-side memory access unit between the CPU datapath and the word-organised, little-endian DataMemory. It accepts one load or store request at a time through a ready/req handshake. Loads issue as word reads with byte and halfword extraction and sign or zero extension. Stores issue as a full-word write, or as a read-modify-write sequence for byte and halfword stores, so the memory only ever sees aligned 32-bit accesses.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; memory word address is {addr[ADDR_W-1:2], 2'b00}.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only while ready=1.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  access size and sign, using RISC-V encoding: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, taken from the low bytes.
- ready  out  1  unit idle; a request is accepted when req and ready are high at a clock edge.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse in place of done for an illegal request.
- rdata  out  32  load result; held until the next load completes.
- mem_A  out  ADDR_W  memory address, always word-aligned.
- mem_WD  out  32  memory write data.
- mem_WE  out  1  memory write enable.
- mem_RD  in  32  memory read data, combinational from mem_A.

## Operation
- On acceptance, latch we, funct3, addr and wdata into internal registers.
- FSM states: IDLE, READ, WRITE, DONE, ERR.
- Transitions out of IDLE on an accepted request:
  - illegal request -> ERR;
  - sw -> WRITE;
  - all loads, sb, sh -> READ.
- READ:
  - mem_A = aligned latched address, mem_WE=0;
  - at the clock edge, capture mem_RD into word_q;
  - load -> DONE, with rdata updated at that same edge;
  - sb/sh -> WRITE.
- WRITE: mem_WE=1 for exactly this cycle; mem_WD is the merged word.
  - sw: mem_WD = wdata.
  - sb: word_q with byte lane addr[1:0] replaced by wdata[7:0].
  - sh: word_q with halfword lane addr[1] replaced by wdata[15:0].
  - Next state is DONE.
- DONE: done=1, then -> IDLE.
- ERR: err=1, no memory access, rdata unchanged, then -> IDLE.
- Load extraction (little-endian: byte 0 = bits [7:0]):
  - lb/lh sign-extend to 32 bits;
  - lbu/lhu zero-extend;
  - lw passes the word through.
- Illegal requests:
  - funct3 values 3, 6 or 7;
  - store with funct3 4 or 5;
  - misalignment, see Configuration.
- In IDLE, DONE and ERR: mem_A holds the last address, mem_WE=0.

## Timing
- ready = (state==IDLE); req is ignored while ready=0. Back-to-back requests are possible: a new request is accepted in the cycle after done.
- Latency, counted from the accept edge to the cycle in which done is high:
  - load: 2 cycles (READ, then DONE);
  - sw: 2 cycles (WRITE, then DONE);
  - sb/sh: 3 cycles (READ, WRITE, then DONE);
  - illegal request: err is high 1 cycle after accept.
- rdata is valid in the done cycle and remains stable afterwards.
- Reset values: state=IDLE, ready=1 from the first cycle after reset, done=0, err=0, rdata=0, mem_A=0, mem_WD=0, mem_WE=0.
- mem_WE = (state==WRITE) && !rst. A reset asserted during the WRITE cycle suppresses that write.
- Reset mid-operation aborts to IDLE without a done or err pulse.
- A request held high through reset is not accepted on the reset edge.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is illegal;
  - such a request goes to ERR and never touches memory.
- LSU_MISALIGN_TRAP_EN undefined:
  - misaligned accesses never raise err;
  - the effective lane offset is forced down: halfword uses addr[1] with addr[0] ignored; word ignores addr[1:0];
  - this matches the memory's own alignment behaviour.
- Illegal funct3 raises err in both builds.

## Structure
- Package lsu_pkg:
  - funct3 encodings F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum lsu_state_t;
  - function is_legal(we, funct3, addr_lo).
- One combinational sub-module, lsu_lane, instantiated once. It performs the load extract/extend and the store merge from (funct3, addr[1:0], word_q, wdata).

## Test plan
- Load sign: memory word at 0x10 = 0x80FF7F01; lb 0x11 -> rdata 0x0000007F; lb 0x12 -> 0xFFFFFFFF; lbu 0x13 -> 0x00000080; lh 0x12 -> 0xFFFF80FF; lw 0x10 -> 0x80FF7F01; done in the 2nd cycle after accept each time.
- sb 0x21 with wdata 0xAB onto word 0x11223344 -> single WE cycle with mem_A=0x20, mem_WD=0x1122AB44; done 3 cycles after accept; a following lw reads 0x1122AB44.
- sw 0x30 with wdata 0xDEADBEEF -> exactly one WE cycle, with no READ cycle, in the cycle after accept; done the next cycle.
- Illegal funct3=3 and sb-with-funct3=4 -> err pulse 1 cycle after accept, mem_WE never high, rdata unchanged.
- Misaligned lw 0x42: with macro -> err and no access; without macro -> done, rdata = word at 0x40.
- Reset in the WRITE cycle of an sh -> mem_WE=0, memory unchanged, ready=1 next cycle, no done. Also: req held during DONE is not accepted until IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and the request legality check for the load/store unit.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } lsu_state_t;

  // Without the trap, misaligned offsets are simply truncated by the lane logic.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic legal;
    logic mis_h;
    logic mis_w;
    mis_h = MISALIGN_TRAP && addr_lo[0];
    mis_w = MISALIGN_TRAP && (addr_lo != 2'b00);
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = !mis_h;
      F3_W:    legal = !mis_w;
      F3_BU:   legal = !we;
      F3_HU:   legal = !we && !mis_h;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: load extraction with sign/zero extension and the
// store merge of new data into the previously read word (little-endian).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_data = {24'd0, sel_byte};
      F3_HU:   load_data = {16'd0, sel_half};
      default: load_data = word;
    endcase

    store_data = wdata;
    case (funct3)
      F3_B: begin
        store_data = word;
        case (addr_lo)
          2'd0:    store_data[7:0]   = wdata[7:0];
          2'd1:    store_data[15:8]  = wdata[7:0];
          2'd2:    store_data[23:16] = wdata[7:0];
          default: store_data[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        store_data = word;
        if (addr_lo[1]) store_data[31:16] = wdata[15:0];
        else            store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit issuing only aligned 32-bit accesses; sub-word
// stores become read-modify-write. Build option: LSU_MISALIGN_TRAP_EN (see lsu_pkg).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_WE,
  input  logic [31:0]       mem_RD
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;

  logic [31:0] lane_word;
  logic [31:0] load_data;
  logic [31:0] store_data;

  // Loads extract straight from the memory bus so rdata lands on the READ edge.
  assign lane_word = (state_q == S_READ) ? mem_RD : word_q;

  lsu_lane u_lane (
    .funct3     (funct3_q),
    .addr_lo    (addr_lo_q),
    .word       (lane_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    wdata_d   = wdata_q;
    word_d    = word_q;
    rdata_d   = rdata_q;
    mem_a_d   = mem_a_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d      = we;
          funct3_d  = funct3;
          addr_lo_d = addr[1:0];
          wdata_d   = wdata;
          if (!is_legal(we, funct3, addr[1:0])) begin
            state_d = S_ERR;
          end else begin
            mem_a_d = {addr[ADDR_W-1:2], 2'b00};
            state_d = (we && funct3 == F3_W) ? S_WRITE : S_READ;
          end
        end
      end
      S_READ: begin
        word_d = mem_RD;
        if (we_q) begin
          state_d = S_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
      wdata_q   <= 32'd0;
      word_q    <= 32'd0;
      rdata_q   <= 32'd0;
      mem_a_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      wdata_q   <= wdata_d;
      word_q    <= word_d;
      rdata_q   <= rdata_d;
      mem_a_q   <= mem_a_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = (state_q == S_ERR);
  assign rdata  = rdata_q;
  assign mem_A  = mem_a_q;
  assign mem_WD = store_data;
  // A reset landing in the WRITE cycle must kill the write immediately.
  assign mem_WE = (state_q == S_WRITE) && !rst;

endmodule
